// File: rtl/fifo_drain_pkg.sv
// Shared FIFO constants and helpers used by the FIFO and its drain logic.
package fifo_drain_pkg;

    // Width of the completed-packet counter.
    localparam int PKT_CNT_W = 16;
    // Width of the in-packet word index.
    localparam int BEAT_W    = 8;
    // Occupancy width of the 2-entry output buffer (0..2).
    localparam int OCC_W     = 2;

    // Advance the in-packet word index, wrapping after the last word.
    function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] beat,
                                                    input logic [BEAT_W-1:0] last_beat);
        return (beat == last_beat) ? '0 : beat + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_drain_skid_buf2.sv
// 2-entry in-order buffer: push appends at the tail, pop removes the head.
module skid_buf2
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;

    // Next-state: ent0 is always the head, ent1 the second-oldest word.
    always_comb begin
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = push_data;
                else               ent1_d = push_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever remains.
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end else begin
                    ent0_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // Occupancy register; the only buffer state that needs reset.
    always_ff @(posedge clk) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    // Data entries carry no reset; they are ignored while occupancy says empty.
    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign occ       = occ_q;
    assign head_data = ent0_q;

    // The read controller must never push into a full buffer without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && occ_q == 2'd2));

endmodule

// File: rtl/fifo_drain.sv
// Drains an upstream FIFO (1-cycle read latency) into a packetised
// valid/ready stream, counting completed packets.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_val,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [PKT_CNT_W-1:0]  pkt_count
);

    if (PKT_LEN < 1 || PKT_LEN > 256) begin : g_bad_pkt_len
        $error("fifo_drain: PKT_LEN must be in 1..256");
    end

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic                 inflight_q, inflight_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [OCC_W-1:0]     occ;
    logic                 push, pop;
    logic [2:0]           committed;

    // Read data is only trusted the cycle after our own request; rd_val
    // from the FIFO can sit high when nothing was asked for.
    assign push = inflight_q & fifo_rd_val;
    assign pop  = m_valid & m_ready;

    // Slots already claimed after this cycle's pop: buffered plus in flight.
    assign committed  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = enable & ~reset & (committed < 3'd2);

    skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    assign m_valid = (occ != '0);
    assign m_last  = m_valid & (beat_q == LAST_BEAT);

    // Next-state for read tracking, in-packet index and packet counter.
    always_comb begin
        inflight_d  = fifo_rd_en;
        beat_d      = beat_q;
        pkt_count_d = pkt_count_q;
        if (pop) begin
            beat_d = next_beat(beat_q, LAST_BEAT);
            if (m_last) pkt_count_d = pkt_count_q + 1'b1;
        end
    end

    // Control registers; reset discards any in-flight read and restarts the packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            beat_q      <= '0;
            pkt_count_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            beat_q      <= beat_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

endmodule
